// File: rtl/btn_pkg.sv
// Shared types and elaboration helpers for the button event array.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } hold_state_e;

    // One spare bit keeps the terminal count representable for any cycle value.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_array_if.sv
// Button pins in, debounced level and one-cycle event pulses out.
interface button_event_array_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] noisy_in;
    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] release_evt;
    logic [N_BTN-1:0] long_press;
    logic [N_BTN-1:0] repeat_evt;

    modport master (
        output noisy_in,
        input  stable, press, release_evt, long_press, repeat_evt
    );

    modport slave (
        input  noisy_in,
        output stable, press, release_evt, long_press, repeat_evt
    );
endinterface

// File: rtl/button_event_array_channel.sv
// One button channel: polarity fix, 2-flop synchroniser, debounce, hold FSM.
module button_event_channel
    import btn_pkg::*;
#(
    parameter int LAST_CYCLES   = 2_000_000,
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic noisy_in,
    output logic stable,
    output logic press,
    output logic release_evt,
    output logic long_press,
    output logic repeat_evt
);
    localparam int DB_W   = cnt_width(LAST_CYCLES);
    localparam int HOLD_W = max_int(cnt_width(LONG_CYCLES), cnt_width(REPEAT_CYCLES));
    localparam bit REPEAT_EN = (REPEAT_CYCLES != 0);
    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(LAST_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = REPEAT_EN ? HOLD_W'(REPEAT_CYCLES - 1) : '0;

    logic [1:0]        sync_q;
    logic              synced;
    logic [DB_W-1:0]   db_cnt;
    logic              stable_d;
    logic              rise;
    logic              fall;
    hold_state_e       state, state_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    logic              long_n;
    logic              repeat_n;

    assign synced = sync_q[1];
    assign rise   = stable & ~stable_d;
    assign fall   = ~stable & stable_d;

    // Polarity is corrected before the synchroniser so an idle-high line resets to "released".
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            db_cnt <= '0;
            stable <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], noisy_in ^ ACTIVE_LOW};
            if (synced == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= ~stable;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d    <= 1'b0;
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
        end else begin
            stable_d    <= stable;
            state       <= state_n;
            hold_cnt    <= hold_cnt_n;
            press       <= rise;
            release_evt <= fall;
            long_press  <= long_n;
            repeat_evt  <= repeat_n;
        end
    end

    // A falling level always wins over a terminal count in the same cycle.
    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt + 1'b1;
        long_n     = 1'b0;
        repeat_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                hold_cnt_n = '0;
                if (rise) state_n = ST_HELD;
            end
            ST_HELD: begin
                if (fall) begin
                    state_n    = ST_IDLE;
                    hold_cnt_n = '0;
                end else if (hold_cnt == LONG_LAST) begin
                    state_n    = ST_LONG;
                    hold_cnt_n = '0;
                    long_n     = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_n    = ST_IDLE;
                    hold_cnt_n = '0;
                end else if (!REPEAT_EN) begin
                    hold_cnt_n = hold_cnt;
                end else if (hold_cnt == REPEAT_LAST) begin
                    hold_cnt_n = '0;
                    repeat_n   = 1'b1;
                end
            end
            default: begin
                state_n    = ST_IDLE;
                hold_cnt_n = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_event_array.sv
// N_BTN independent button channels sharing only clock and reset.
module button_event_array
    import btn_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int LAST_CYCLES   = 2_000_000,
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    button_event_array_if.slave bus
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_event_channel #(
            .LAST_CYCLES  (LAST_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .noisy_in   (bus.noisy_in[i]),
            .stable     (bus.stable[i]),
            .press      (bus.press[i]),
            .release_evt(bus.release_evt[i]),
            .long_press (bus.long_press[i]),
            .repeat_evt (bus.repeat_evt[i])
        );
    end

endmodule

// File: tb/tb_button_event_array.sv
// Directed bench for button_event_array: debounce, events, hold timing, reset, polarity.
module tb_button_event_array;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    button_event_array_if #(.N_BTN(2)) bus();
    button_event_array_if #(.N_BTN(1)) bus_al();

    button_event_array #(
        .N_BTN(2), .LAST_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    button_event_array #(
        .N_BTN(1), .LAST_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst(rst), .bus(bus_al.slave)
    );

    // Per-channel view: {stable, press, release, long_press, repeat}
    logic [4:0] ch0, ch1, chal;
    assign ch0  = {bus.stable[0], bus.press[0], bus.release_evt[0], bus.long_press[0], bus.repeat_evt[0]};
    assign ch1  = {bus.stable[1], bus.press[1], bus.release_evt[1], bus.long_press[1], bus.repeat_evt[1]};
    assign chal = {bus_al.stable[0], bus_al.press[0], bus_al.release_evt[0], bus_al.long_press[0], bus_al.repeat_evt[0]};

    // Advance to just after the next rising edge; inputs set here belong to the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.noisy_in    = 2'b00;
        bus_al.noisy_in = 1'b1;
        step();
        step();
        total++;
        if ({ch1, ch0, chal} !== 15'd0) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b", {ch1, ch0, chal}, 15'd0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            total++;
            if ({ch1, ch0, chal} !== 15'd0) begin
                bad++;
                $display("FAIL post_reset_quiet k=%0d got=%b want=%b", k, {ch1, ch0, chal}, 15'd0);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [4:0] e0;
        bus.noisy_in = 2'b01;
        for (int k = 1; k <= 75; k++) begin
            step();
            e0 = {k >= 6 && k < 66, k == 7, k == 67, k == 27,
                  k >= 35 && k <= 59 && ((k - 35) % 8) == 0};
            total++;
            if ({ch1, ch0} !== {5'd0, e0}) begin
                bad++;
                $display("FAIL clean_press k=%0d got=%b want=%b", k, {ch1, ch0}, {5'd0, e0});
            end
            if (k == 60) bus.noisy_in = 2'b00;
        end
    endtask

    task automatic test_bounce();
        logic [4:0]  e0;
        logic [31:0] pat;
        // 1-, 2-, 3-cycle glitches each followed by one low cycle, then held high cycles 9..19
        pat = 32'h000F_FEED;
        bus.noisy_in[0] = pat[0];
        for (int k = 1; k <= 32; k++) begin
            step();
            e0 = {k >= 15 && k < 26, k == 16, k == 27, 1'b0, 1'b0};
            total++;
            if ({ch1, ch0} !== {5'd0, e0}) begin
                bad++;
                $display("FAIL bounce k=%0d got=%b want=%b", k, {ch1, ch0}, {5'd0, e0});
            end
            bus.noisy_in[0] = (k <= 31) ? pat[k] : 1'b0;
        end
    endtask

    task automatic test_short_press();
        logic [4:0] e0;
        bus.noisy_in = 2'b01;
        for (int k = 1; k <= 25; k++) begin
            step();
            e0 = {k >= 6 && k < 18, k == 7, k == 19, 1'b0, 1'b0};
            total++;
            if ({ch1, ch0} !== {5'd0, e0}) begin
                bad++;
                $display("FAIL short_press k=%0d got=%b want=%b", k, {ch1, ch0}, {5'd0, e0});
            end
            if (k == 12) bus.noisy_in = 2'b00;
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [4:0] e0;
        bus.noisy_in = 2'b01;
        for (int k = 1; k <= 55; k++) begin
            step();
            if (k < 31)
                e0 = {k >= 6, k == 7, 1'b0, k == 27, 1'b0};
            else
                e0 = {k >= 37 && k < 51, k == 38, k == 52, 1'b0, 1'b0};
            total++;
            if ({ch1, ch0} !== {5'd0, e0}) begin
                bad++;
                $display("FAIL reset_mid_hold k=%0d got=%b want=%b", k, {ch1, ch0}, {5'd0, e0});
            end
            if (k == 30) rst = 1'b1;
            if (k == 31) rst = 1'b0;
            if (k == 45) bus.noisy_in = 2'b00;
        end
    endtask

    task automatic test_two_channels();
        logic [4:0] e0, e1;
        bus.noisy_in = 2'b11;
        for (int k = 1; k <= 40; k++) begin
            step();
            e0 = {k >= 6 && k < 36, k == 7, k == 37, k == 27, k == 35};
            e1 = {k >= 6 && k < 21, k == 7, k == 22, 1'b0, 1'b0};
            total++;
            if ({ch1, ch0} !== {e1, e0}) begin
                bad++;
                $display("FAIL two_channels k=%0d got=%b want=%b", k, {ch1, ch0}, {e1, e0});
            end
            if (k == 15) bus.noisy_in[1] = 1'b0;
            if (k == 30) bus.noisy_in[0] = 1'b0;
        end
    endtask

    task automatic test_active_low();
        logic [4:0] e;
        for (int k = 1; k <= 10; k++) begin
            step();
            total++;
            if (chal !== 5'd0) begin
                bad++;
                $display("FAIL active_low_idle k=%0d got=%b want=%b", k, chal, 5'd0);
            end
        end
        bus_al.noisy_in = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            step();
            e = {k >= 6 && k < 16, k == 7, k == 17, 1'b0, 1'b0};
            total++;
            if (chal !== e) begin
                bad++;
                $display("FAIL active_low_press k=%0d got=%b want=%b", k, chal, e);
            end
            if (k == 10) bus_al.noisy_in = 1'b1;
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.noisy_in    = 2'b00;
        bus_al.noisy_in = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_press();
        test_reset_mid_hold();
        test_two_channels();
        test_active_low();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
